obi_memcheck_master: RTL and testbench

OBI initiator that writes a deterministic data/tag pattern over a word range of the data RAM and its parallel DIFT tag memory, then reads the range back and counts mismatches. It drives the same data-side OBI and tag signals the CV32E40P core drives. This lets the core-less bench and the boot self-test exercise `simple_mem`/`tag_mem` without running firmware.

---
 rtl/obi_memcheck_pkg.sv | 27 ++
 rtl/obi_memcheck_master.sv | 164 ++++++++++++++++
 tb/tb_obi_memcheck_master.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/obi_memcheck_pkg.sv
// Shared types and pattern helpers for the OBI memory checker.
// Pure combinational functions, no latency.
// No flow control here; used by the initiator for issue and check.
package obi_memcheck_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_WDRAIN = 3'd2,
    S_READ   = 3'd3,
    S_RDRAIN = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Data word written to (and expected back from) a given byte address.
  function automatic logic [31:0] pattern_data(input logic [31:0] seed, input logic [31:0] addr);
    return seed ^ addr;
  endfunction

  // Tag nibble for a word; only the index parity matters, so only bit 0 is taken.
  function automatic logic [3:0] pattern_tag(input logic idx_lsb, input logic inv);
    return {4{idx_lsb ^ inv}};
  endfunction

endpackage

// File: rtl/obi_memcheck_master.sv
// OBI initiator: writes a data/tag pattern over a word range, reads it back, counts mismatches.
// Zero-wait memory: N writes, drain, N reads, drain; done in cycle 2N+3 after start (cycle 1 if N=0).
// Requests are held until granted; at most MAX_OUTSTANDING unanswered beats; responses in order.
module obi_memcheck_master
  import obi_memcheck_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic [31:0]      seed,
  input  logic             tag_inv,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      first_err_addr,
  output logic             proto_err,
  output logic             req,
  input  logic             gnt,
  output logic [31:0]      addr,
  output logic             we,
  output logic [3:0]       be,
  output logic [31:0]      wdata,
  input  logic             rvalid,
  input  logic [31:0]      rdata,
  output logic             we_tag,
  output logic [3:0]       wdata_tag,
  input  logic             gnt_tag,
  input  logic             rvalid_tag,
  input  logic [3:0]       rdata_tag
);

  state_t           state, state_n;
  logic [31:0]      base_q, seed_q;
  logic [CNT_W-1:0] num_q;
  logic             inv_q;
  logic [CNT_W-1:0] iss_idx, rsp_idx;
  logic [3:0]       out_cnt, out_nxt;
  logic             grant, resp, last_iss, req_ok, rd_phase, mismatch, proto_viol;
  logic [31:0]      base_al, exp_addr, addr_inc;

  assign base_al    = base_addr & ~32'd3;
  assign grant      = req & gnt & gnt_tag;
  // A response with nothing outstanding is a protocol error and is not counted.
  assign resp       = rvalid & (out_cnt != 4'd0);
  assign out_nxt    = out_cnt + 4'(grant) - 4'(resp);
  assign req_ok     = out_nxt < 4'(MAX_OUTSTANDING);
  assign last_iss   = (iss_idx + CNT_W'(1)) == num_q;
  assign rd_phase   = (state == S_READ) || (state == S_RDRAIN);
  assign exp_addr   = base_q + (32'(rsp_idx) << 2);
  assign addr_inc   = addr + 32'd4;
  assign mismatch   = (rdata != pattern_data(seed_q, exp_addr)) ||
                      (rdata_tag != pattern_tag(rsp_idx[0], inv_q));
  assign proto_viol = (req & (gnt != gnt_tag)) | (rvalid != rvalid_tag) |
                      (rvalid & (out_cnt == 4'd0));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Phase sequencing: drains wait until every granted beat has been answered.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = (num_words == '0) ? S_DONE : S_WRITE;
      S_WRITE:  if (grant && last_iss) state_n = S_WDRAIN;
      S_WDRAIN: if (out_nxt == 4'd0) state_n = S_READ;
      S_READ:   if (grant && last_iss) state_n = S_RDRAIN;
      S_RDRAIN: if (out_nxt == 4'd0) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Request issue, outstanding tracking, read-back checking and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      req            <= 1'b0;
      addr           <= '0;
      we             <= 1'b0;
      we_tag         <= 1'b0;
      be             <= '0;
      wdata          <= '0;
      wdata_tag      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      proto_err      <= 1'b0;
      base_q         <= '0;
      seed_q         <= '0;
      num_q          <= '0;
      inv_q          <= 1'b0;
      iss_idx        <= '0;
      rsp_idx        <= '0;
      out_cnt        <= '0;
    end else begin
      busy    <= (state_n != S_IDLE);
      done    <= (state_n == S_DONE);
      out_cnt <= out_nxt;

      if (state == S_IDLE && start) proto_err <= 1'b0;
      else if (proto_viol)          proto_err <= 1'b1;

      if (state == S_IDLE && start) begin
        base_q         <= base_al;
        seed_q         <= seed;
        num_q          <= num_words;
        inv_q          <= tag_inv;
        err_count      <= '0;
        first_err_addr <= '0;
        iss_idx        <= '0;
        rsp_idx        <= '0;
        be             <= BE_ALL;
        req            <= (num_words != '0);
        addr           <= base_al;
        we             <= 1'b1;
        we_tag         <= 1'b1;
        wdata          <= pattern_data(seed, base_al);
        wdata_tag      <= pattern_tag(1'b0, tag_inv);
      end

      // Request fields only advance on a grant, so they stay stable while stalled.
      if (state == S_WRITE || state == S_READ) begin
        if (grant && last_iss) begin
          req <= 1'b0;
        end else begin
          req <= req_ok;
          if (grant) begin
            iss_idx   <= iss_idx + CNT_W'(1);
            addr      <= addr_inc;
            wdata     <= pattern_data(seed_q, addr_inc);
            wdata_tag <= pattern_tag(~iss_idx[0], inv_q);
          end
        end
      end

      if (state == S_WDRAIN && state_n == S_READ) begin
        req       <= 1'b1;
        iss_idx   <= '0;
        addr      <= base_q;
        we        <= 1'b0;
        we_tag    <= 1'b0;
        wdata     <= pattern_data(seed_q, base_q);
        wdata_tag <= pattern_tag(1'b0, inv_q);
      end

      if (rd_phase && resp) begin
        rsp_idx <= rsp_idx + CNT_W'(1);
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (err_count == '0) first_err_addr <= exp_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_obi_memcheck_master.sv
// Bench for obi_memcheck_master with an OBI memory responder and a reference model.
// Responder grants on negedge-driven inputs; responses are delivered in order after 1..3 cycles.
// The model tracks expected addresses, data, tags, error counts and outstanding beats.
module tb_obi_memcheck_master;
  localparam int MAXO = 2;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic rst, start, tag_inv;
  logic [31:0] base_addr, seed;
  logic [CW-1:0] num_words;
  logic busy, done, proto_err;
  logic [CW-1:0] err_count;
  logic [31:0] first_err_addr;
  logic req, gnt, we, rvalid, we_tag, gnt_tag, rvalid_tag;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be, wdata_tag, rdata_tag;

  always #5 clk = ~clk;

  obi_memcheck_master #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .seed(seed), .tag_inv(tag_inv), .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .proto_err(proto_err), .req(req), .gnt(gnt),
    .addr(addr), .we(we), .be(be), .wdata(wdata), .rvalid(rvalid), .rdata(rdata),
    .we_tag(we_tag), .wdata_tag(wdata_tag), .gnt_tag(gnt_tag), .rvalid_tag(rvalid_tag),
    .rdata_tag(rdata_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state, set up per run.
  logic [31:0] m_base, m_seed;
  logic        m_inv;
  int          m_mode;   // 0 clean, 1 flip rdata[0] at 0x1008, 2 tags read as 0, 3 random stalls, 4 one gnt/gnt_tag split
  int          wi, ri, exp_err, tb_out;
  logic [31:0] exp_first;
  bit          inj_done;
  logic [31:0] mem  [logic [31:0]];
  logic [3:0]  tmem [logic [31:0]];

  typedef struct {
    int unsigned due;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
    int          idx;
  } rsp_t;
  rsp_t pend[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] exp_tag(input int i, input logic inv);
    return (((i % 2) == 1) != inv) ? 4'hF : 4'h0;
  endfunction

  // Memory responder and request checker, acting mid-cycle.
  logic g, gt, grant_c, resp_c, prev_stall;
  logic [31:0] p_addr, p_wdata, ea, d;
  logic        p_we, p_we_tag;
  logic [3:0]  p_wtag, t;
  rsp_t        e;
  initial begin
    gnt = 0; gnt_tag = 0; rvalid = 0; rvalid_tag = 0; rdata = 0; rdata_tag = 0;
    prev_stall = 0; tb_out = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        gnt = 0; gnt_tag = 0; rvalid = 0; rvalid_tag = 0;
        tb_out = 0; prev_stall = 0;
      end else begin
        resp_c = 0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          e = pend.pop_front();
          resp_c = 1;
          rvalid = 1; rvalid_tag = 1; rdata = e.data; rdata_tag = e.tag;
          if (!e.we && (e.data != (m_seed ^ e.addr) || e.tag != exp_tag(e.idx, m_inv))) begin
            if (exp_err == 0) exp_first = e.addr;
            exp_err++;
          end
        end else begin
          rvalid = 0; rvalid_tag = 0; rdata = $urandom; rdata_tag = 4'h0;
        end
        if (prev_stall) begin
          chk("hold_req", 32'(req), 1);
          chk("hold_addr", addr, p_addr);
          chk("hold_wdata", wdata, p_wdata);
          chk("hold_we", 32'({we, we_tag}), 32'({p_we, p_we_tag}));
          chk("hold_wtag", 32'(wdata_tag), 32'(p_wtag));
        end
        g = (m_mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
        gt = g;
        if (m_mode == 4 && req && !inj_done) begin
          g = 1'b1; gt = 1'b0; inj_done = 1;
        end
        gnt = g; gnt_tag = gt;
        grant_c = req && g && gt;
        if (grant_c) begin
          chk("outstanding_le_max", ((tb_out + 1 - (resp_c ? 1 : 0)) <= MAXO) ? 1 : 0, 1);
          chk("be", 32'(be), 32'hF);
          chk("we_tag_eq_we", 32'(we_tag), 32'(we));
          e.we = we; e.addr = addr;
          if (we) begin
            ea = m_base + 32'(4 * wi);
            chk("wr_addr", addr, ea);
            chk("wr_data", wdata, m_seed ^ ea);
            chk("wr_tag", 32'(wdata_tag), 32'(exp_tag(wi, m_inv)));
            mem[addr] = wdata; tmem[addr] = wdata_tag;
            e.data = $urandom; e.tag = 4'h0; e.idx = wi;
            wi++;
          end else begin
            ea = m_base + 32'(4 * ri);
            chk("rd_addr", addr, ea);
            d = mem.exists(addr) ? mem[addr] : 32'h0;
            t = tmem.exists(addr) ? tmem[addr] : 4'h0;
            if (m_mode == 1 && addr == 32'h1008) d[0] = ~d[0];
            if (m_mode == 2) t = 4'h0;
            e.data = d; e.tag = t; e.idx = ri;
            ri++;
          end
          e.due = cyc + ((m_mode == 3) ? $urandom_range(1, 3) : 1);
          pend.push_back(e);
        end
        tb_out = tb_out + (grant_c ? 1 : 0) - (resp_c ? 1 : 0);
        prev_stall = req && !grant_c;
        p_addr = addr; p_wdata = wdata; p_we = we; p_we_tag = we_tag; p_wtag = wdata_tag;
      end
    end
  end

  task automatic run(input logic [31:0] b, input int n, input logic [31:0] s, input logic inv,
                     input int mode, input int poke, input int exp_done);
    int k, done_k, busy_low;
    @(negedge clk);
    m_base = b & 32'hFFFF_FFFC; m_seed = s; m_inv = inv; m_mode = mode;
    wi = 0; ri = 0; exp_err = 0; exp_first = 0; inj_done = 0;
    base_addr = b; num_words = CW'(n); seed = s; tag_inv = inv; start = 1;
    @(negedge clk);
    start = 0;
    k = 1; done_k = -1; busy_low = 0;
    while (k < 3000 && done_k < 0) begin
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) done_k = k;
      else begin
        if (k == poke) begin
          start = 1; base_addr = 32'hDEAD_0000; num_words = CW'(7);
        end
        @(negedge clk);
        start = 0; base_addr = b; num_words = CW'(n);
        k++;
      end
    end
    chk("done_seen", (done_k >= 0) ? 1 : 0, 1);
    if (exp_done >= 0) chk("done_cycle", done_k, exp_done);
    chk("busy_until_done", busy_low, 0);
    chk("err_count", 32'(err_count), exp_err);
    chk("first_err_addr", first_err_addr, exp_first);
    chk("proto_err", 32'(proto_err), (mode == 4) ? 1 : 0);
    chk("writes_issued", wi, n);
    chk("reads_issued", ri, n);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; base_addr = 0; num_words = 0; seed = 0; tag_inv = 0; m_mode = 0;
    m_base = 0; m_seed = 0; m_inv = 0; wi = 0; ri = 0; exp_err = 0; exp_first = 0; inj_done = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_proto", 32'(proto_err), 0);
    chk("rst_addr", addr, 0);
    chk("rst_we", 32'({we, we_tag}), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wtag", 32'(wdata_tag), 0);
    chk("rst_be", 32'(be), 0);
    rst = 0;

    run(32'h1000, 4, 32'hA5A5_0000, 1'b0, 0, -1, 11);
    run(32'h1000, 4, 32'hA5A5_0000, 1'b0, 1, -1, 11);
    chk("flip_err_count", 32'(err_count), 1);
    chk("flip_first", first_err_addr, 32'h1008);
    run(32'h1000, 4, 32'hA5A5_0000, 1'b0, 2, -1, 11);
    chk("tag0_err_count", 32'(err_count), 2);
    chk("tag0_first", first_err_addr, 32'h1004);
    run(32'h3000, 0, 32'h1234_5678, 1'b0, 0, -1, 1);
    run(32'h1000, 4, 32'h0F0F_F0F0, 1'b1, 0, 3, 11);
    run(32'hFFFF_FFF8, 4, 32'hCAFE_0000, 1'b0, 0, -1, 11);
    run(32'h0000_4003, 5, 32'h5555_AAAA, 1'b1, 0, -1, 13);
    for (int r = 0; r < 3; r++)
      run($urandom, 64, $urandom, 1'($urandom_range(0, 1)), 3, -1, -1);
    run(32'h1000, 4, 32'h7777_0000, 1'b0, 4, -1, -1);
    run(32'h1000, 4, 32'h7777_0000, 1'b0, 0, -1, 11);

    // Reset in the middle of an 8-word run.
    @(negedge clk);
    m_base = 32'h2000; m_seed = 32'h1111_2222; m_inv = 0; m_mode = 0;
    wi = 0; ri = 0; exp_err = 0; exp_first = 0;
    base_addr = 32'h2000; num_words = CW'(8); seed = 32'h1111_2222; tag_inv = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_req", 32'(req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_err", 32'(err_count), 0);
    mem.delete(); tmem.delete();
    run(32'h2000, 8, 32'h1111_2222, 1'b0, 0, -1, 19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
